lutram_sync_fifo: RTL and testbench
===================================

Name: lutram_sync_fifo

Overview:
- Synchronous first-word-fall-through FIFO controller built around the team's LUT-RAM primitive `sramLutRam` (sync write, async read).
- Generates write/read addresses, write enable, full/empty flags and fill level; sits between a producing pipeline stage and a consuming stage.
- Provides a single-clock elastic buffer for bus, DMA and CPU-side queues.

Parameters:
- nrOfAddressBits, 5, log2 of depth; depth = 2**nrOfAddressBits (default 32 entries).
- nrOfDataBits, 32, width of each stored word.

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- push  input  1  write request.
- pushData  input  nrOfDataBits  word written when push is accepted.
- full  output  1  high when fillLevel == depth.
- pop  input  1  read/consume request.
- popData  output  nrOfDataBits  current head word, valid whenever empty == 0.
- empty  output  1  high when fillLevel == 0.
- fillLevel  output  nrOfAddressBits+1  number of stored words, 0..depth.

Behaviour:
- Reset (async assert, sync-safe deassert by system): writePtr=0, readPtr=0, fillLevel=0, empty=1, full=0, popData=0. RAM contents are not cleared.
- pushAccepted = push & ~full. On the clock edge: RAM[writePtr] <= pushData; writePtr <= writePtr+1, wrapping modulo depth.
- popAccepted = pop & ~empty. On the clock edge: readPtr <= readPtr+1, wrapping modulo depth.
- fillLevel: +1 if push only, -1 if pop only, unchanged if both or neither accepted.
- empty and full are registered and consistent with fillLevel in the same cycle.
- FWFT timing: popData = empty ? 0 : RAM[readPtr] (combinational).
  - A word pushed in cycle N is visible on popData in cycle N+1.
  - The consumer samples popData in the same cycle it asserts pop.
- Push while full: ignored; data dropped, no state change.
- Pop while empty: ignored, no state change.
- Push+pop while empty: push accepted, pop ignored; fillLevel becomes 1.
- Push+pop while full: pop accepted, push ignored (no full bypass); fillLevel becomes depth-1.
- Push+pop otherwise: both accepted; fillLevel unchanged; pointers both advance.
- Pointer wrap: pointers are nrOfAddressBits wide and wrap naturally; full/empty are derived from fillLevel, not pointer comparison.
- Reset mid-operation: all in-flight state discarded immediately; next accepted push lands at address 0.
- No state machine beyond the pointer/count registers; latency push→visible = 1 cycle.

Optional Feature:
- Macro: LUTRAM_FIFO_ERROR_FLAGS_EN.
- Defined: extra outputs overflow (1) and underflow (1), both sticky and cleared only by reset.
  - overflow is set the cycle after push & full; underflow is set the cycle after pop & empty.
  - Both reset to 0.
- Undefined: ports absent, no extra logic; ignored requests are silent.

Decomposition:
- Shared include `lutram_fifo_defs.vh`: default depth/width constants and a DEPTH macro computed from address bits.
- One sub-module: the existing `sramLutRam`, instantiated with matching parameters.
  - writeEnable = pushAccepted, writeAddress = writePtr, readAddress = readPtr.
- All control logic stays in lutram_sync_fifo.

Test Plan:
- Reset then idle: after reset, empty=1, full=0, fillLevel=0, popData=0 for 5 cycles.
- Push 0x11,0x22,0x33 on consecutive cycles, then pop 3 times: popData reads 0x11,0x22,0x33 in order; fillLevel goes 1,2,3,2,1,0; empty=1 at the end.
- Push 32 words 0..31: full=1, fillLevel=32. A 33rd push of 0xDEAD is dropped. Pop all 32: values 0..31 are returned and 0xDEAD is never seen. With the macro defined, overflow=1.
- Wrap: 40 cycles of push+pop with fillLevel held at 4; data order preserved across address 31→0; fillLevel stays 4.
- Simultaneous events:
  - Push+pop on empty: fillLevel=1, popData equals the pushed word next cycle.
  - Push+pop on full: fillLevel=31 and the pushed word is dropped.
- Reset mid-operation: with 7 words stored, pulse reset asynchronously between edges: flags and fillLevel clear immediately. Next push 0xA5 then pop returns 0xA5.

Source files
------------

// File: rtl/lutram_sync_fifo_pkg.sv
// Shared defaults and helpers for the LUT-RAM based FWFT FIFO.
package lutram_sync_fifo_pkg;

   localparam int unsigned DefAddrBits = 5;
   localparam int unsigned DefDataBits = 32;

   // Accepted request combination in one cycle.
   typedef enum logic [1:0] {
      OpNone = 2'b00,
      OpPop  = 2'b01,
      OpPush = 2'b10,
      OpBoth = 2'b11
   } fifo_op_e;

   function automatic int unsigned fifo_depth(input int unsigned addr_bits);
      return 32'd1 << addr_bits;
   endfunction

endpackage

// File: rtl/lutram_sync_fifo_ram.sv
// LUT-RAM primitive: synchronous write, asynchronous read, contents not reset.
module sramLutRam
   import lutram_sync_fifo_pkg::*;
#(
   parameter int unsigned nrOfAddressBits = DefAddrBits,
   parameter int unsigned nrOfDataBits    = DefDataBits
) (
   input  logic                       clock_i,
   input  logic                       write_enable_i,
   input  logic [nrOfAddressBits-1:0] write_address_i,
   input  logic [nrOfDataBits-1:0]    write_data_i,
   input  logic [nrOfAddressBits-1:0] read_address_i,
   output logic [nrOfDataBits-1:0]    read_data_o
);

   localparam int unsigned Depth = 32'd1 << nrOfAddressBits;

   logic [nrOfDataBits-1:0] mem_q [Depth];

   // Storage array written on the rising edge when enabled.
   always_ff @(posedge clock_i) begin
      if (write_enable_i) begin
         mem_q[write_address_i] <= write_data_i;
      end
   end

   assign read_data_o = mem_q[read_address_i];

endmodule

// File: rtl/lutram_sync_fifo.sv
// Single-clock first-word-fall-through FIFO controller around sramLutRam.
// Optional sticky overflow/underflow outputs: define LUTRAM_FIFO_ERROR_FLAGS_EN.
module lutram_sync_fifo
   import lutram_sync_fifo_pkg::*;
#(
   parameter int unsigned nrOfAddressBits = DefAddrBits,
   parameter int unsigned nrOfDataBits    = DefDataBits
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic [nrOfDataBits-1:0]    pushData,
   output logic                       full,
   input  logic                       pop,
   output logic [nrOfDataBits-1:0]    popData,
   output logic                       empty,
`ifdef LUTRAM_FIFO_ERROR_FLAGS_EN
   output logic                       overflow,
   output logic                       underflow,
`endif
   output logic [nrOfAddressBits:0]   fillLevel
);

   localparam int unsigned Depth = fifo_depth(nrOfAddressBits);
   localparam logic [nrOfAddressBits:0] DepthLvl = (nrOfAddressBits + 1)'(Depth);

   logic [nrOfAddressBits-1:0] write_ptr_q, write_ptr_d;
   logic [nrOfAddressBits-1:0] read_ptr_q, read_ptr_d;
   logic [nrOfAddressBits:0]   fill_q, fill_d;
   logic                       empty_q, empty_d;
   logic                       full_q, full_d;
   logic                       push_acc, pop_acc;
   logic [nrOfDataBits-1:0]    ram_rdata;
   fifo_op_e                   op;

   assign push_acc = push & ~full_q;
   assign pop_acc  = pop & ~empty_q;
   assign op       = fifo_op_e'({push_acc, pop_acc});

   // Next-state for pointers, fill count and flags derived from the count.
   always_comb begin
      write_ptr_d = write_ptr_q;
      read_ptr_d  = read_ptr_q;
      fill_d      = fill_q;
      if (push_acc) write_ptr_d = write_ptr_q + 1'b1;
      if (pop_acc)  read_ptr_d  = read_ptr_q + 1'b1;
      unique case (op)
         OpPush:  fill_d = fill_q + 1'b1;
         OpPop:   fill_d = fill_q - 1'b1;
         default: fill_d = fill_q;
      endcase
      empty_d = (fill_d == '0);
      full_d  = (fill_d == DepthLvl);
   end

   // Controller state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         write_ptr_q <= '0;
         read_ptr_q  <= '0;
         fill_q      <= '0;
         empty_q     <= 1'b1;
         full_q      <= 1'b0;
      end else begin
         write_ptr_q <= write_ptr_d;
         read_ptr_q  <= read_ptr_d;
         fill_q      <= fill_d;
         empty_q     <= empty_d;
         full_q      <= full_d;
      end
   end

`ifdef LUTRAM_FIFO_ERROR_FLAGS_EN
   logic overflow_q, underflow_q;

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (push & full_q)  overflow_q  <= 1'b1;
         if (pop & empty_q)  underflow_q <= 1'b1;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`endif

   sramLutRam #(
      .nrOfAddressBits(nrOfAddressBits),
      .nrOfDataBits   (nrOfDataBits)
   ) u_ram (
      .clock_i        (clock),
      .write_enable_i (push_acc),
      .write_address_i(write_ptr_q),
      .write_data_i   (pushData),
      .read_address_i (read_ptr_q),
      .read_data_o    (ram_rdata)
   );

   // Head word is forced to zero while empty so stale RAM never leaks out.
   assign popData   = empty_q ? '0 : ram_rdata;
   assign empty     = empty_q;
   assign full      = full_q;
   assign fillLevel = fill_q;

endmodule

// File: tb/tb_lutram_sync_fifo.sv
// Directed self-checking bench for lutram_sync_fifo (default 32 x 32).
`timescale 1ns/1ps
module tb_lutram_sync_fifo;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        push = 1'b0;
   logic [31:0] pushData = '0;
   logic        full;
   logic        pop = 1'b0;
   logic [31:0] popData;
   logic        empty;
   logic [5:0]  fillLevel;
`ifdef LUTRAM_FIFO_ERROR_FLAGS_EN
   logic        overflow;
   logic        underflow;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   lutram_sync_fifo #(
      .nrOfAddressBits(5),
      .nrOfDataBits   (32)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .push     (push),
      .pushData (pushData),
      .full     (full),
      .pop      (pop),
      .popData  (popData),
      .empty    (empty),
`ifdef LUTRAM_FIFO_ERROR_FLAGS_EN
      .overflow (overflow),
      .underflow(underflow),
`endif
      .fillLevel(fillLevel)
   );

   // Advance one rising edge and settle 1ns past it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (empty !== 1'b1 || full !== 1'b0 || fillLevel !== 6'd0 || popData !== 32'd0) begin
            errors++;
            $display("FAIL reset_idle c%0d: empty=%b full=%b fill=%0d data=%h, want 1 0 0 0",
                     c, empty, full, fillLevel, popData);
         end
         tick();
      end
`ifdef LUTRAM_FIFO_ERROR_FLAGS_EN
      checks++;
      if (overflow !== 1'b0 || underflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: ovf=%b unf=%b, want 0 0", overflow, underflow);
      end
`endif
   endtask

   task automatic test_order();
      logic [31:0] vals [3];
      vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
      for (int i = 0; i < 3; i++) begin
         push = 1'b1; pushData = vals[i];
         tick();
         checks++;
         if (fillLevel !== 6'(i + 1)) begin
            errors++;
            $display("FAIL order_fill_push%0d: got %0d want %0d", i, fillLevel, i + 1);
         end
      end
      push = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (popData !== vals[i]) begin
            errors++;
            $display("FAIL order_data%0d: got %h want %h", i, popData, vals[i]);
         end
         pop = 1'b1;
         tick();
         checks++;
         if (fillLevel !== 6'(2 - i)) begin
            errors++;
            $display("FAIL order_fill_pop%0d: got %0d want %0d", i, fillLevel, 2 - i);
         end
      end
      pop = 1'b0;
      checks++;
      if (empty !== 1'b1) begin
         errors++;
         $display("FAIL order_empty: got %b want 1", empty);
      end
   endtask

   task automatic test_full();
      for (int i = 0; i < 32; i++) begin
         push = 1'b1; pushData = 32'(i);
         tick();
      end
      checks++;
      if (full !== 1'b1 || fillLevel !== 6'd32 || empty !== 1'b0) begin
         errors++;
         $display("FAIL full_flags: full=%b fill=%0d empty=%b, want 1 32 0", full, fillLevel, empty);
      end
      pushData = 32'hDEAD;
      tick();
      push = 1'b0;
      checks++;
      if (full !== 1'b1 || fillLevel !== 6'd32) begin
         errors++;
         $display("FAIL full_drop: full=%b fill=%0d, want 1 32", full, fillLevel);
      end
`ifdef LUTRAM_FIFO_ERROR_FLAGS_EN
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_set: got %b want 1", overflow);
      end
`endif
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (popData !== 32'(i)) begin
            errors++;
            $display("FAIL full_drain%0d: got %h want %h", i, popData, i);
         end
         pop = 1'b1;
         tick();
      end
      pop = 1'b0;
      checks++;
      if (empty !== 1'b1 || fillLevel !== 6'd0 || popData !== 32'd0) begin
         errors++;
         $display("FAIL full_after_drain: empty=%b fill=%0d data=%h, want 1 0 0",
                  empty, fillLevel, popData);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 4; i++) begin
         push = 1'b1; pushData = 32'(100 + i);
         tick();
      end
      for (int k = 0; k < 40; k++) begin
         checks++;
         if (popData !== 32'(100 + k)) begin
            errors++;
            $display("FAIL wrap_data%0d: got %0d want %0d", k, popData, 100 + k);
         end
         push = 1'b1; pop = 1'b1; pushData = 32'(104 + k);
         tick();
         checks++;
         if (fillLevel !== 6'd4) begin
            errors++;
            $display("FAIL wrap_fill%0d: got %0d want 4", k, fillLevel);
         end
      end
      push = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (popData !== 32'(140 + i)) begin
            errors++;
            $display("FAIL wrap_tail%0d: got %0d want %0d", i, popData, 140 + i);
         end
         pop = 1'b1;
         tick();
      end
      pop = 1'b0;
      checks++;
      if (empty !== 1'b1) begin
         errors++;
         $display("FAIL wrap_empty: got %b want 1", empty);
      end
   endtask

   task automatic test_simultaneous();
      push = 1'b1; pop = 1'b1; pushData = 32'h55;
      tick();
      push = 1'b0; pop = 1'b0;
      checks++;
      if (fillLevel !== 6'd1 || popData !== 32'h55) begin
         errors++;
         $display("FAIL simul_empty: fill=%0d data=%h, want 1 00000055", fillLevel, popData);
      end
`ifdef LUTRAM_FIFO_ERROR_FLAGS_EN
      checks++;
      if (underflow !== 1'b1) begin
         errors++;
         $display("FAIL underflow_set: got %b want 1", underflow);
      end
`endif
      pop = 1'b1;
      tick();
      pop = 1'b0;
      for (int i = 0; i < 32; i++) begin
         push = 1'b1; pushData = 32'(32'h200 + i);
         tick();
      end
      checks++;
      if (full !== 1'b1 || popData !== 32'h200) begin
         errors++;
         $display("FAIL simul_prefull: full=%b data=%h, want 1 00000200", full, popData);
      end
      push = 1'b1; pop = 1'b1; pushData = 32'hBEEF;
      tick();
      push = 1'b0; pop = 1'b0;
      checks++;
      if (fillLevel !== 6'd31 || full !== 1'b0) begin
         errors++;
         $display("FAIL simul_full: fill=%0d full=%b, want 31 0", fillLevel, full);
      end
      for (int i = 1; i < 32; i++) begin
         checks++;
         if (popData !== 32'(32'h200 + i)) begin
            errors++;
            $display("FAIL simul_drain%0d: got %h want %h", i, popData, 32'h200 + i);
         end
         pop = 1'b1;
         tick();
      end
      pop = 1'b0;
      checks++;
      if (empty !== 1'b1 || fillLevel !== 6'd0) begin
         errors++;
         $display("FAIL simul_end: empty=%b fill=%0d, want 1 0", empty, fillLevel);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 7; i++) begin
         push = 1'b1; pushData = 32'(32'h300 + i);
         tick();
      end
      push = 1'b0;
      checks++;
      if (fillLevel !== 6'd7) begin
         errors++;
         $display("FAIL mid_fill: got %0d want 7", fillLevel);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (fillLevel !== 6'd0 || empty !== 1'b1 || full !== 1'b0 || popData !== 32'd0) begin
         errors++;
         $display("FAIL mid_async_clear: fill=%0d empty=%b full=%b data=%h, want 0 1 0 0",
                  fillLevel, empty, full, popData);
      end
      #1 reset = 1'b0;
      tick();
`ifdef LUTRAM_FIFO_ERROR_FLAGS_EN
      checks++;
      if (overflow !== 1'b0 || underflow !== 1'b0) begin
         errors++;
         $display("FAIL mid_flags_clear: ovf=%b unf=%b, want 0 0", overflow, underflow);
      end
`endif
      push = 1'b1; pushData = 32'hA5;
      tick();
      push = 1'b0;
      checks++;
      if (popData !== 32'hA5 || fillLevel !== 6'd1) begin
         errors++;
         $display("FAIL mid_repush: data=%h fill=%0d, want 000000a5 1", popData, fillLevel);
      end
      pop = 1'b1;
      tick();
      pop = 1'b0;
      checks++;
      if (empty !== 1'b1) begin
         errors++;
         $display("FAIL mid_final_empty: got %b want 1", empty);
      end
   endtask

   initial begin
      test_reset();
      test_order();
      test_full();
      test_wrap();
      test_simultaneous();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
